// File: rtl/scr1_tcm_dport_pkg.sv
// Shared types and constants for the TCM port-B data controller.
// Also holds the alignment rule used both when a request is accepted and when it is issued.
package scr1_tcm_dport_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DATA  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE    = 2'b00,
        WIDTH_HALF    = 2'b01,
        WIDTH_WORD    = 2'b10,
        WIDTH_ILLEGAL = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ER   = 2'b10
    } resp_e;

    function automatic logic addr_misaligned(width_e width, logic [1:0] addr_lo);
        case (width)
            WIDTH_BYTE: return 1'b0;
            WIDTH_HALF: return addr_lo[0];
            WIDTH_WORD: return |addr_lo;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/scr1_tcm_dport_ctrl_if.sv
// Core-side dmem handshake and memory port-B signals of the TCM data controller.
// The slave modport is the controller's view; master is the environment's view.
interface scr1_tcm_dport_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              dmem_req;
    logic              dmem_cmd;
    logic [1:0]        dmem_width;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_req_ack;
    logic [31:0]       dmem_rdata;
    logic [1:0]        dmem_resp;

    logic              mem_gnt;
    logic              mem_renb;
    logic              mem_wenb;
    logic [3:0]        mem_webb;
    logic [ADDR_W-3:0] mem_addrb;
    logic [31:0]       mem_datab;
    logic [31:0]       mem_qb;

    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        input  mem_gnt, mem_qb,
        output mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab
    );

    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        output mem_gnt, mem_qb,
        input  mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab
    );
endinterface

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane steering: write enables, lane-replicated write data, misalignment flag,
// and right-justified, zero-extended read data for one access.
module scr1_tcm_lane_align
    import scr1_tcm_dport_pkg::*;
(
    input  width_e             width,
    input  logic [1:0]         addr_lo,
    input  logic [31:0]        wdata,
    input  logic [31:0]        qb,
    output logic [LANES-1:0]   webb,
    output logic [31:0]        datab,
    output logic [31:0]        rdata,
    output logic               misaligned
);

    logic [31:0] shifted;

    assign shifted    = qb >> {addr_lo, 3'b000};
    assign misaligned = addr_misaligned(width, addr_lo);

    always_comb begin
        webb  = '0;
        datab = wdata;
        rdata = '0;
        case (width)
            WIDTH_BYTE: begin
                webb  = 4'b0001 << addr_lo;
                datab = {LANES{wdata[BYTE_W-1:0]}};
                rdata = {24'h0, shifted[7:0]};
            end
            WIDTH_HALF: begin
                webb  = 4'b0011 << addr_lo;
                datab = {2{wdata[15:0]}};
                rdata = {16'h0, shifted[15:0]};
            end
            WIDTH_WORD: begin
                webb  = 4'b1111;
                rdata = shifted;
            end
            default: begin
                webb  = '0;
            end
        endcase
    end

endmodule

// File: rtl/scr1_tcm_dport_ctrl.sv
// Port-B initiator for the dual-port TCM: accepts core dmem requests, issues one
// memory access per request under an external grant, and returns the aligned response.
module scr1_tcm_dport_ctrl
    import scr1_tcm_dport_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    scr1_tcm_dport_ctrl_if.slave bus
);

    state_e              state;
    logic                req_cmd;
    width_e              req_width;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_err;

    logic                accept;
    logic                new_err;
    logic                issue;
    logic                data_ph;
    logic [LANES-1:0]    al_webb;
    logic [DATA_W-1:0]   al_datab;
    logic [DATA_W-1:0]   al_rdata;
    logic                al_misaligned;

    assign bus.dmem_req_ack = !rst && (state == ST_IDLE || state == ST_DATA);
    assign accept           = bus.dmem_req && bus.dmem_req_ack;
    assign new_err          = addr_misaligned(width_e'(bus.dmem_width), bus.dmem_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_cmd   <= CMD_RD;
            req_width <= WIDTH_BYTE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DATA: begin
                    if (accept) begin
                        req_cmd   <= bus.dmem_cmd;
                        req_width <= width_e'(bus.dmem_width);
                        req_addr  <= bus.dmem_addr;
                        req_wdata <= bus.dmem_wdata;
                        req_err   <= new_err;
                        // Illegal requests skip the memory and answer on the next cycle.
                        state     <= new_err ? ST_DATA : ST_ISSUE;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_gnt) state <= ST_DATA;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    scr1_tcm_lane_align u_align (
        .width      (req_width),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .qb         (bus.mem_qb),
        .webb       (al_webb),
        .datab      (al_datab),
        .rdata      (al_rdata),
        .misaligned (al_misaligned)
    );

    // Outputs are decodes of registered state; rst gates them so nothing leaks while in reset.
    assign issue   = !rst && state == ST_ISSUE && !al_misaligned;
    assign data_ph = !rst && state == ST_DATA;

    assign bus.mem_renb  = issue && req_cmd == CMD_RD;
    assign bus.mem_wenb  = issue && req_cmd == CMD_WR;
    assign bus.mem_webb  = bus.mem_wenb ? al_webb : '0;
    assign bus.mem_datab = bus.mem_wenb ? al_datab : '0;
    assign bus.mem_addrb = issue ? req_addr[ADDR_W-1:2] : '0;

    assign bus.dmem_resp  = !data_ph ? RESP_IDLE : (req_err ? RESP_ER : RESP_OK);
    assign bus.dmem_rdata = (data_ph && !req_err && req_cmd == CMD_RD) ? al_rdata : '0;

endmodule
